// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared rank constants, shoe FSM states, LFSR taps and width helpers
package baccarat_pkg;
  localparam int NUM_RANKS = 13;
  localparam logic [3:0] RANK_ACE = 4'd1;
  localparam logic [3:0] RANK_JACK = 4'd11;
  localparam logic [3:0] RANK_QUEEN = 4'd12;
  localparam logic [3:0] RANK_KING = 4'd13;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic {IDLE, SCAN} shoe_state_t;
  function automatic int cnt_w(input int decks);
    return $clog2(4 * decks + 1);
  endfunction
  function automatic int rem_w(input int decks);
    return $clog2(52 * decks + 1);
  endfunction
endpackage

// File: rtl/baccarat_shoe_if.sv
// baccarat_shoe_if: deal request/response and shoe status between game FSM and shoe
interface baccarat_shoe_if
  import baccarat_pkg::*;
#(
  parameter int NUM_DECKS = 8
);
  localparam int REM_W = rem_w(NUM_DECKS);
  logic deal_req;
  logic reshuffle;
  logic [3:0] card;
  logic card_valid;
  logic busy;
  logic deal_err;
  logic [REM_W-1:0] remaining;
  logic empty;
  logic cut_reached;
  modport master(
    output deal_req, reshuffle,
    input card, card_valid, busy, deal_err, remaining, empty, cut_reached
  );
  modport slave(
    input deal_req, reshuffle,
    output card, card_valid, busy, deal_err, remaining, empty, cut_reached
  );
endinterface

// File: rtl/baccarat_shoe_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16
  import baccarat_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetb,
  output logic [15:0] q
);
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) q <= SEED;
    else q <= {q[14:0], ^(q & LFSR_TAPS)};
endmodule

// File: rtl/baccarat_shoe.sv
// baccarat_shoe: multi-deck shoe dealing ranks 1..13 without replacement
module baccarat_shoe
  import baccarat_pkg::*;
#(
  parameter int NUM_DECKS = 8,
  parameter int CUT_CARDS = 16,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clock,
  input logic resetb,
  baccarat_shoe_if.slave bus
);
  localparam int CNT_W = cnt_w(NUM_DECKS);
  localparam int REM_W = rem_w(NUM_DECKS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(4 * NUM_DECKS);
  localparam logic [REM_W-1:0] FULL_REM = REM_W'(52 * NUM_DECKS);
  localparam logic FULL_CUT = (52 * NUM_DECKS) < CUT_CARDS;
  localparam logic [3:0] LAST_IDX = RANK_KING - RANK_ACE;
  logic [15:0] lfsr_q;
  logic unused_lfsr;
  logic [3:0] start_idx;
  logic [3:0] ptr;
  logic [CNT_W-1:0] cnt [NUM_RANKS];
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_dec;
  logic hit;
  shoe_state_t state;
  lfsr16 #(.SEED(SEED)) u_lfsr (.clock(clock), .resetb(resetb), .q(lfsr_q));
  assign unused_lfsr = ^lfsr_q[15:4];
  assign start_idx = (lfsr_q[3:0] >= NUM_RANKS[3:0]) ? lfsr_q[3:0] - NUM_RANKS[3:0] : lfsr_q[3:0];
  assign hit = cnt[ptr] != '0;
  assign rem_dec = rem_q - REM_W'(1);
  assign bus.remaining = rem_q;
  // SCAN is only entered with cards left, so the ptr walk always terminates on a hit
  always_ff @(posedge clock or negedge resetb)
    if (!resetb) begin
      for (int i = 0; i < NUM_RANKS; i++) cnt[i] <= FULL_CNT;
      rem_q <= FULL_REM;
      state <= IDLE;
      ptr <= '0;
      bus.card <= '0;
      bus.card_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.deal_err <= 1'b0;
      bus.empty <= 1'b0;
      bus.cut_reached <= FULL_CUT;
    end else if (bus.reshuffle) begin
      for (int i = 0; i < NUM_RANKS; i++) cnt[i] <= FULL_CNT;
      rem_q <= FULL_REM;
      state <= IDLE;
      bus.card_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.deal_err <= 1'b0;
      bus.empty <= 1'b0;
      bus.cut_reached <= FULL_CUT;
    end else begin
      bus.card_valid <= 1'b0;
      bus.deal_err <= 1'b0;
      if (state == IDLE) begin
        if (bus.deal_req && rem_q != '0) begin
          ptr <= start_idx;
          state <= SCAN;
          bus.busy <= 1'b1;
        end else bus.deal_err <= bus.deal_req;
      end else if (hit) begin
        cnt[ptr] <= cnt[ptr] - CNT_W'(1);
        rem_q <= rem_dec;
        bus.empty <= rem_dec == '0;
        bus.cut_reached <= 32'(rem_dec) < CUT_CARDS;
        bus.card <= ptr + RANK_ACE;
        bus.card_valid <= 1'b1;
        bus.busy <= 1'b0;
        state <= IDLE;
      end else ptr <= (ptr == LAST_IDX) ? 4'd0 : ptr + 4'd1;
    end
endmodule

// File: tb/tb_baccarat_shoe.sv
// tb_baccarat_shoe: directed checks of the shoe against a rank-count and LFSR reference model
module tb_baccarat_shoe;
  import baccarat_pkg::*;
  logic clock = 1'b0;
  logic resetb = 1'b1;
  always #5 clock = ~clock;
  baccarat_shoe_if #(.NUM_DECKS(8)) bus8 ();
  baccarat_shoe_if #(.NUM_DECKS(1)) bus1 ();
  baccarat_shoe #(.NUM_DECKS(8)) dut8 (.clock(clock), .resetb(resetb), .bus(bus8));
  baccarat_shoe #(.NUM_DECKS(1), .CUT_CARDS(16)) dut1 (.clock(clock), .resetb(resetb), .bus(bus1));
  int n_tests = 0;
  int n_fail = 0;
  int n_valid = 0;
  int nv;
  int m_cnt [13];
  int m_rem;
  int seen [13];
  logic [3:0] last_card;
  logic [15:0] m_lfsr;
  always @(posedge clock or negedge resetb)
    if (!resetb) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  always @(negedge clock) if (bus1.card_valid) n_valid++;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic int start_of(input logic [15:0] x);
    int v;
    v = int'(x[3:0]);
    return v >= 13 ? v - 13 : v;
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic model_full();
    for (int i = 0; i < 13; i++) m_cnt[i] = 4;
    m_rem = 52;
  endtask
  // want>=0 waits until the LFSR start index equals want before requesting
  task automatic deal(input int want, input bit hold);
    int idx, d, r, lat;
    lat = 0;
    if (want >= 0) begin
      while (start_of(m_lfsr) != want && lat < 300) begin
        tick();
        lat++;
      end
      if (lat >= 300) chk("steer_timeout", lat, 0);
    end
    idx = start_of(m_lfsr);
    d = 0;
    while (d < 13 && m_cnt[(idx + d) % 13] == 0) d++;
    r = (idx + d) % 13;
    bus1.deal_req = 1'b1;
    tick();
    if (!hold) bus1.deal_req = 1'b0;
    chk("busy_after_req", int'(bus1.busy), 1);
    lat = 1;
    while (!bus1.card_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("card", int'(bus1.card), r + 1);
    chk("latency", lat, d + 2);
    if (bus1.card >= 4'd1 && bus1.card <= 4'd13) seen[int'(bus1.card) - 1]++;
    m_cnt[r]--;
    m_rem--;
    chk("remaining", int'(bus1.remaining), m_rem);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus1.deal_req = 1'b0;
    bus1.reshuffle = 1'b0;
    bus8.deal_req = 1'b0;
    bus8.reshuffle = 1'b0;
    for (int i = 0; i < 13; i++) seen[i] = 0;
    #2 resetb = 1'b0;
    #20;
    chk("rst8_remaining", int'(bus8.remaining), 416);
    chk("rst8_empty", int'(bus8.empty), 0);
    chk("rst8_cut", int'(bus8.cut_reached), 0);
    chk("rst8_valid", int'(bus8.card_valid), 0);
    chk("rst8_busy", int'(bus8.busy), 0);
    chk("rst8_err", int'(bus8.deal_err), 0);
    chk("rst1_remaining", int'(bus1.remaining), 52);
    chk("rst1_card", int'(bus1.card), 0);
    #10 resetb = 1'b1;
    tick();
    model_full();
    for (int k = 0; k < 52; k++) deal(-1, 1'b1);
    chk("full_empty", int'(bus1.empty), 1);
    chk("full_remaining", int'(bus1.remaining), 0);
    chk("full_cut", int'(bus1.cut_reached), 1);
    bus1.deal_req = 1'b0;
    tick();
    chk("full_pulses", n_valid, 52);
    for (int i = 0; i < 13; i++) chk($sformatf("rank%0d_seen", i + 1), seen[i], 4);
    chk("idle_no_err", int'(bus1.deal_err), 0);
    bus1.deal_req = 1'b1;
    tick();
    bus1.deal_req = 1'b0;
    chk("empty_err", int'(bus1.deal_err), 1);
    chk("empty_no_valid", int'(bus1.card_valid), 0);
    chk("empty_busy", int'(bus1.busy), 0);
    chk("empty_remaining", int'(bus1.remaining), 0);
    tick();
    chk("err_pulse_end", int'(bus1.deal_err), 0);
    chk("empty_pulses", n_valid, 52);
    bus1.reshuffle = 1'b1;
    tick();
    bus1.reshuffle = 1'b0;
    model_full();
    chk("resh_remaining", int'(bus1.remaining), 52);
    chk("resh_empty", int'(bus1.empty), 0);
    chk("resh_cut", int'(bus1.cut_reached), 0);
    repeat (36) deal(-1, 1'b0);
    chk("cut_at16", int'(bus1.cut_reached), 0);
    deal(-1, 1'b0);
    chk("cut_at15", int'(bus1.cut_reached), 1);
    last_card = bus1.card;
    bus1.deal_req = 1'b1;
    tick();
    bus1.deal_req = 1'b0;
    nv = n_valid;
    chk("abort_busy", int'(bus1.busy), 1);
    bus1.reshuffle = 1'b1;
    tick();
    bus1.reshuffle = 1'b0;
    chk("abort_busy_clr", int'(bus1.busy), 0);
    chk("abort_valid", int'(bus1.card_valid), 0);
    chk("abort_remaining", int'(bus1.remaining), 52);
    chk("abort_empty", int'(bus1.empty), 0);
    chk("abort_cut", int'(bus1.cut_reached), 0);
    chk("abort_card_held", int'(bus1.card), int'(last_card));
    tick();
    chk("abort_no_card", int'(bus1.card_valid), 0);
    bus1.deal_req = 1'b1;
    bus1.reshuffle = 1'b1;
    tick();
    bus1.deal_req = 1'b0;
    bus1.reshuffle = 1'b0;
    chk("simul_busy", int'(bus1.busy), 0);
    tick();
    chk("simul_busy2", int'(bus1.busy), 0);
    chk("abort_pulses", n_valid, nv);
    model_full();
    for (int r = 0; r < 12; r++) repeat (4) deal(r, 1'b0);
    chk("kings_left", int'(bus1.remaining), 4);
    deal(0, 1'b0);
    deal(12, 1'b0);
    deal(-1, 1'b0);
    deal(5, 1'b0);
    chk("last_empty", int'(bus1.empty), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/baccarat_shoe.md
Name: baccarat_shoe

Overview:
- Multi-deck card shoe for the baccarat datapath; successor to the single-rank random dealer.
- Deals ranks 1..13 without replacement from NUM_DECKS standard decks, tracking per-rank remaining counts.
- Provides request/valid dealing, a cut-card warning, empty/error signalling and one-cycle reshuffle.
- Sits between the top-level baccarat state machine and the hand/score datapath.

Parameters:
- NUM_DECKS, 8, decks in shoe (1..8); each rank starts at 4*NUM_DECKS.
- CUT_CARDS, 16, cut_reached asserts when remaining < CUT_CARDS.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.
- CNT_W, derived $clog2(4*NUM_DECKS+1), per-rank counter width.
- REM_W, derived $clog2(52*NUM_DECKS+1), remaining width.

Ports:
- clock  in  1  sole clock, rising edge
- resetb  in  1  asynchronous active-low reset
- deal_req  in  1  request one card; sampled only when busy=0
- reshuffle  in  1  restore full shoe; highest priority
- card  out  4  dealt rank 1..13; valid when card_valid=1, holds last value otherwise
- card_valid  out  1  one-cycle pulse, card delivered
- busy  out  1  high while scanning for a card
- deal_err  out  1  one-cycle pulse: deal_req while shoe empty
- remaining  out  REM_W  cards left in shoe
- empty  out  1  remaining==0
- cut_reached  out  1  remaining < CUT_CARDS

Behaviour:
- Reset (async, resetb=0): every rank count = 4*NUM_DECKS; remaining = 52*NUM_DECKS; card=0; card_valid=0; busy=0; deal_err=0; empty=0; cut_reached=0 unless 52*NUM_DECKS<CUT_CARDS; state IDLE; LFSR=SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clock, including while busy.
- Start index: idx = lfsr[3:0]; if idx>=13, idx-=13 (range 0..12); rank = idx+1.
- FSM states: IDLE, SCAN.
- IDLE, deal_req=1, remaining>0: latch idx as ptr -> SCAN; busy=1 from the next cycle.
- IDLE, deal_req=1, remaining==0: deal_err pulses next cycle; stay IDLE.
- SCAN, count[ptr]>0: on that edge decrement count[ptr] and remaining; card=ptr+1; card_valid=1 for one cycle; -> IDLE (busy=0 same cycle as card_valid).
- SCAN, count[ptr]==0: ptr = (ptr==12) ? 0 : ptr+1; stay SCAN.
- SCAN entered only with remaining>0, so a hit is guaranteed within 13 cycles.
- Latency: request edge to card_valid is 2..14 cycles.
- deal_req while busy: ignored, not queued. deal_req held high in IDLE deals back-to-back, one card per completion.
- reshuffle=1 on an edge: all counts full, remaining full, state IDLE, busy=0, card_valid=0, deal_err=0; any scan in flight aborts with no card. reshuffle overrides a simultaneous hit; card is unchanged; the LFSR is not reset.
- Flags are registered functions of post-update remaining; empty and cut_reached update on the same edge as the decrement.
- Counters never underflow or wrap: a decrement occurs only when count>0.

Decomposition:
- Shared package baccarat_pkg: rank constants (RANK_ACE=1 .. RANK_KING=13, NUM_RANKS=13), state enum typedef, LFSR tap constant, CNT_W/REM_W helper functions.
- Sub-module lfsr16 (clock, resetb, SEED parameter, q[15:0]), reusable by other random sources.
- Rank counters and FSM stay in baccarat_shoe.

Test Plan:
- Reset with NUM_DECKS=8 -> remaining=416, empty=0, cut_reached=0, card_valid=0, busy=0.
- NUM_DECKS=1, hold deal_req high until empty -> exactly 52 card_valid pulses; each rank 1..13 seen exactly 4 times; every valid card in 1..13; empty=1 and remaining=0 after pulse 52; each latency <=14 cycles.
- Empty shoe, pulse deal_req -> deal_err pulses one cycle; no card_valid; remaining stays 0.
- NUM_DECKS=1, CUT_CARDS=16: deal 36 cards -> cut_reached=0 (remaining=16); deal 1 more -> cut_reached=1 on the same edge remaining becomes 15.
- Assert reshuffle while busy=1 -> next cycle busy=0, no card_valid, remaining=52*NUM_DECKS, empty=0; reshuffle simultaneous with deal_req -> no deal started.
- Deplete all ranks except 13 (force via dealing plus checks) -> next request scans and returns card=13, with latency matching the scan distance from the start index.
